// File: rtl/axi_rd_arbiter_if.sv
// Read-channel bundle between two AXI masters, the arbiter and one slave port.
// The slave modport is the arbiter's view; the master modport is the environment driving it.
interface axi_rd_arbiter_if #(
    parameter int ID_W   = 4,
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3
);
    logic [ID_W-1:0]   ARID_M0_i;
    logic [ADDR_W-1:0] ARADDR_M0_i;
    logic [LEN_W-1:0]  ARLEN_M0_i;
    logic [SIZE_W-1:0] ARSIZE_M0_i;
    logic [1:0]        ARBURST_M0_i;
    logic              ARVALID_M0_i;
    logic              ARREADY_M0_o;
    logic [ID_W-1:0]   RID_M0_o;
    logic [DATA_W-1:0] RDATA_M0_o;
    logic [1:0]        RRESP_M0_o;
    logic              RLAST_M0_o;
    logic              RVALID_M0_o;
    logic              RREADY_M0_i;

    logic [ID_W-1:0]   ARID_M1_i;
    logic [ADDR_W-1:0] ARADDR_M1_i;
    logic [LEN_W-1:0]  ARLEN_M1_i;
    logic [SIZE_W-1:0] ARSIZE_M1_i;
    logic [1:0]        ARBURST_M1_i;
    logic              ARVALID_M1_i;
    logic              ARREADY_M1_o;
    logic [ID_W-1:0]   RID_M1_o;
    logic [DATA_W-1:0] RDATA_M1_o;
    logic [1:0]        RRESP_M1_o;
    logic              RLAST_M1_o;
    logic              RVALID_M1_o;
    logic              RREADY_M1_i;

    logic [IDS_W-1:0]  ARID_S_o;
    logic [ADDR_W-1:0] ARADDR_S_o;
    logic [LEN_W-1:0]  ARLEN_S_o;
    logic [SIZE_W-1:0] ARSIZE_S_o;
    logic [1:0]        ARBURST_S_o;
    logic              ARVALID_S_o;
    logic              ARREADY_S_i;
    logic [IDS_W-1:0]  RID_S_i;
    logic [DATA_W-1:0] RDATA_S_i;
    logic [1:0]        RRESP_S_i;
    logic              RLAST_S_i;
    logic              RVALID_S_i;
    logic              RREADY_S_o;

    modport slave (
        input  ARID_M0_i, ARADDR_M0_i, ARLEN_M0_i, ARSIZE_M0_i, ARBURST_M0_i, ARVALID_M0_i, RREADY_M0_i,
        output ARREADY_M0_o, RID_M0_o, RDATA_M0_o, RRESP_M0_o, RLAST_M0_o, RVALID_M0_o,
        input  ARID_M1_i, ARADDR_M1_i, ARLEN_M1_i, ARSIZE_M1_i, ARBURST_M1_i, ARVALID_M1_i, RREADY_M1_i,
        output ARREADY_M1_o, RID_M1_o, RDATA_M1_o, RRESP_M1_o, RLAST_M1_o, RVALID_M1_o,
        output ARID_S_o, ARADDR_S_o, ARLEN_S_o, ARSIZE_S_o, ARBURST_S_o, ARVALID_S_o, RREADY_S_o,
        input  ARREADY_S_i, RID_S_i, RDATA_S_i, RRESP_S_i, RLAST_S_i, RVALID_S_i
    );

    modport master (
        output ARID_M0_i, ARADDR_M0_i, ARLEN_M0_i, ARSIZE_M0_i, ARBURST_M0_i, ARVALID_M0_i, RREADY_M0_i,
        input  ARREADY_M0_o, RID_M0_o, RDATA_M0_o, RRESP_M0_o, RLAST_M0_o, RVALID_M0_o,
        output ARID_M1_i, ARADDR_M1_i, ARLEN_M1_i, ARSIZE_M1_i, ARBURST_M1_i, ARVALID_M1_i, RREADY_M1_i,
        input  ARREADY_M1_o, RID_M1_o, RDATA_M1_o, RRESP_M1_o, RLAST_M1_o, RVALID_M1_o,
        input  ARID_S_o, ARADDR_S_o, ARLEN_S_o, ARSIZE_S_o, ARBURST_S_o, ARVALID_S_o, RREADY_S_o,
        output ARREADY_S_i, RID_S_i, RDATA_S_i, RRESP_S_i, RLAST_S_i, RVALID_S_i
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-master round-robin read arbiter for one AXI slave port, one burst in flight.
// Optional decode-error responder for out-of-window addresses: define AXI_RD_ARB_DECERR_EN.
module axi_rd_arbiter #(
    parameter int ID_W   = 4,
    parameter int IDS_W  = 8,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 4,
    parameter int SIZE_W = 3,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = ADDR_W'(32'h0000_0000),
    parameter logic [ADDR_W-1:0] RANGE_BYTES = ADDR_W'(32'h0001_0000)
) (
    input  logic       AXI_CLK_i,
    input  logic       AXI_RST_i,
    axi_rd_arbiter_if.slave bus,
    output logic [1:0] dbg_state_o
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a raised valid holds its payload until that transfer.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
`ifdef AXI_RD_ARB_DECERR_EN
        ,
        ERR  = 2'd3
`endif
    } state_e;

    localparam logic [3:0] TAG_M0 = 4'b0001;
    localparam logic [3:0] TAG_M1 = 4'b0010;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic [IDS_W-1:0]  arid_q, arid_d;
    logic [ADDR_W-1:0] araddr_q, araddr_d;
    logic [LEN_W-1:0]  arlen_q, arlen_d;
    logic [SIZE_W-1:0] arsize_q, arsize_d;
    logic [1:0]        arburst_q, arburst_d;

    logic              pick_m1;
    logic [IDS_W-1:0]  sel_arid;
    logic [ADDR_W-1:0] sel_araddr;
    logic [LEN_W-1:0]  sel_arlen;
    logic [SIZE_W-1:0] sel_arsize;
    logic [1:0]        sel_arburst;
    logic              sel_rready;
    logic              arready_m0, arready_m1;

    logic              g_rvalid, g_rlast, rready_s;
    logic [ID_W-1:0]   g_rid;
    logic [DATA_W-1:0] g_rdata;
    logic [1:0]        g_rresp;

`ifdef AXI_RD_ARB_DECERR_EN
    localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
    localparam logic [ADDR_W:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, RANGE_BYTES};
    logic [LEN_W-1:0] beat_q, beat_d;
    logic             addr_ok;
    assign addr_ok = ({1'b0, sel_araddr} >= WIN_LO) && ({1'b0, sel_araddr} < WIN_HI);
`else
    logic unused_cfg;
    assign unused_cfg = ^{BASE_ADDR, RANGE_BYTES};
`endif

    // Routing follows the registered grant; the tag bits of the returned RID are not trusted.
    logic unused_rid_tag;
    assign unused_rid_tag = ^bus.RID_S_i[IDS_W-1:ID_W];

    always_comb begin
        pick_m1 = bus.ARVALID_M1_i && (!bus.ARVALID_M0_i || !last_grant_q);
        if (pick_m1) begin
            sel_arid    = {TAG_M1, bus.ARID_M1_i};
            sel_araddr  = bus.ARADDR_M1_i;
            sel_arlen   = bus.ARLEN_M1_i;
            sel_arsize  = bus.ARSIZE_M1_i;
            sel_arburst = bus.ARBURST_M1_i;
        end else begin
            sel_arid    = {TAG_M0, bus.ARID_M0_i};
            sel_araddr  = bus.ARADDR_M0_i;
            sel_arlen   = bus.ARLEN_M0_i;
            sel_arsize  = bus.ARSIZE_M0_i;
            sel_arburst = bus.ARBURST_M0_i;
        end
        sel_rready = grant_q ? bus.RREADY_M1_i : bus.RREADY_M0_i;
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        arid_d       = arid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arsize_d     = arsize_q;
        arburst_d    = arburst_q;
        arready_m0   = 1'b0;
        arready_m1   = 1'b0;
`ifdef AXI_RD_ARB_DECERR_EN
        beat_d       = beat_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.ARVALID_M0_i || bus.ARVALID_M1_i) begin
                    arready_m0   = !pick_m1;
                    arready_m1   = pick_m1;
                    grant_d      = pick_m1;
                    last_grant_d = pick_m1;
                    arid_d       = sel_arid;
                    araddr_d     = sel_araddr;
                    arlen_d      = sel_arlen;
                    arsize_d     = sel_arsize;
                    arburst_d    = sel_arburst;
                    state_d      = ADDR;
`ifdef AXI_RD_ARB_DECERR_EN
                    beat_d       = '0;
                    if (!addr_ok) state_d = ERR;
`endif
                end
            end
            ADDR: begin
                if (bus.ARREADY_S_i) state_d = DATA;
            end
            DATA: begin
                if (bus.RVALID_S_i && sel_rready && bus.RLAST_S_i) state_d = IDLE;
            end
`ifdef AXI_RD_ARB_DECERR_EN
            ERR: begin
                if (sel_rready) begin
                    if (beat_q == arlen_q) state_d = IDLE;
                    else                   beat_d  = beat_q + LEN_W'(1);
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        g_rvalid = 1'b0;
        g_rid    = '0;
        g_rdata  = '0;
        g_rresp  = 2'b00;
        g_rlast  = 1'b0;
        rready_s = 1'b0;
        case (state_q)
            DATA: begin
                g_rvalid = bus.RVALID_S_i;
                g_rid    = bus.RID_S_i[ID_W-1:0];
                g_rdata  = bus.RDATA_S_i;
                g_rresp  = bus.RRESP_S_i;
                g_rlast  = bus.RLAST_S_i;
                rready_s = sel_rready;
            end
`ifdef AXI_RD_ARB_DECERR_EN
            ERR: begin
                g_rvalid = 1'b1;
                g_rid    = arid_q[ID_W-1:0];
                g_rresp  = 2'b11;
                g_rlast  = (beat_q == arlen_q);
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge AXI_CLK_i or negedge AXI_RST_i) begin
        if (!AXI_RST_i) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arsize_q     <= '0;
            arburst_q    <= '0;
`ifdef AXI_RD_ARB_DECERR_EN
            beat_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arsize_q     <= arsize_d;
            arburst_q    <= arburst_d;
`ifdef AXI_RD_ARB_DECERR_EN
            beat_q       <= beat_d;
`endif
        end
    end

    // ARREADY is gated by reset so nothing handshakes while reset is held.
    assign bus.ARREADY_M0_o = arready_m0 && AXI_RST_i;
    assign bus.ARREADY_M1_o = arready_m1 && AXI_RST_i;

    assign bus.ARVALID_S_o = (state_q == ADDR);
    assign bus.ARID_S_o    = arid_q;
    assign bus.ARADDR_S_o  = araddr_q;
    assign bus.ARLEN_S_o   = arlen_q;
    assign bus.ARSIZE_S_o  = arsize_q;
    assign bus.ARBURST_S_o = arburst_q;
    assign bus.RREADY_S_o  = rready_s;

    assign bus.RVALID_M0_o = !grant_q && g_rvalid;
    assign bus.RID_M0_o    = grant_q ? '0 : g_rid;
    assign bus.RDATA_M0_o  = grant_q ? '0 : g_rdata;
    assign bus.RRESP_M0_o  = grant_q ? 2'b00 : g_rresp;
    assign bus.RLAST_M0_o  = !grant_q && g_rlast;

    assign bus.RVALID_M1_o = grant_q && g_rvalid;
    assign bus.RID_M1_o    = grant_q ? g_rid : '0;
    assign bus.RDATA_M1_o  = grant_q ? g_rdata : '0;
    assign bus.RRESP_M1_o  = grant_q ? g_rresp : 2'b00;
    assign bus.RLAST_M1_o  = grant_q && g_rlast;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Bench for axi_rd_arbiter: directed scenarios plus randomized rounds against a
// transaction-level model of grant order, AR forwarding and burst delivery.
module tb_axi_rd_arbiter;
    localparam int ID_W   = 4;
    localparam int IDS_W  = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int LEN_W  = 4;
    localparam int SIZE_W = 3;
    localparam logic [31:0] BASE  = 32'h1000_0000;
    localparam logic [31:0] RANGE = 32'h0001_0000;
`ifdef AXI_RD_ARB_DECERR_EN
    localparam bit DECERR_ON = 1'b1;
`else
    localparam bit DECERR_ON = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axi_rd_arbiter_if #(.ID_W(ID_W), .IDS_W(IDS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                        .LEN_W(LEN_W), .SIZE_W(SIZE_W)) bus ();
    logic [1:0] dbg_state;

    axi_rd_arbiter #(.ID_W(ID_W), .IDS_W(IDS_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
                     .LEN_W(LEN_W), .SIZE_W(SIZE_W), .BASE_ADDR(BASE), .RANGE_BYTES(RANGE)) dut (
        .AXI_CLK_i  (clk),
        .AXI_RST_i  (rst_n),
        .bus        (bus),
        .dbg_state_o(dbg_state)
    );

    // ---------------- stimulus state ----------------
    logic              m_arv[2];
    logic [ID_W-1:0]   m_id[2];
    logic [ADDR_W-1:0] m_addr[2];
    logic [LEN_W-1:0]  m_len[2];
    logic [SIZE_W-1:0] m_size[2];
    logic [1:0]        m_burst[2];
    logic              m_rrdy[2];
    logic              s_arrdy, s_rv, s_rlast;
    logic [IDS_W-1:0]  s_rid;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_rresp;

    logic              o_arrdy[2], o_rv[2], o_rlast[2];
    logic [ID_W-1:0]   o_rid[2];
    logic [DATA_W-1:0] o_rdata[2];
    logic [1:0]        o_rresp[2];

    // knobs for directed scenarios (-1 = random / off)
    int stall_cfg   = -1;
    int rrdy_mode   = 0;
    int abort_after = -1;
    int rereq       = 0;

    // ---------------- scoreboard ----------------
    logic [DATA_W+2:0] exp_q[$];   // {last, resp, data}
    int vectors = 0;
    int errors  = 0;
    int model_last = 1;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int model_pick(input bit v0, input bit v1);
        if (v0 && v1) return (model_last == 0) ? 1 : 0;
        return v0 ? 0 : 1;
    endfunction

    function automatic bit model_fwd(input logic [ADDR_W-1:0] a);
        longint la;
        if (!DECERR_ON) return 1'b1;
        la = longint'(a);
        return (la >= longint'(BASE)) && (la < longint'(BASE) + longint'(RANGE));
    endfunction

    function automatic logic [3:0] tag_of(input int g);
        return (g == 0) ? 4'b0001 : 4'b0010;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive();
        bus.ARVALID_M0_i = m_arv[0];   bus.ARVALID_M1_i = m_arv[1];
        bus.ARID_M0_i    = m_id[0];    bus.ARID_M1_i    = m_id[1];
        bus.ARADDR_M0_i  = m_addr[0];  bus.ARADDR_M1_i  = m_addr[1];
        bus.ARLEN_M0_i   = m_len[0];   bus.ARLEN_M1_i   = m_len[1];
        bus.ARSIZE_M0_i  = m_size[0];  bus.ARSIZE_M1_i  = m_size[1];
        bus.ARBURST_M0_i = m_burst[0]; bus.ARBURST_M1_i = m_burst[1];
        bus.RREADY_M0_i  = m_rrdy[0];  bus.RREADY_M1_i  = m_rrdy[1];
        bus.ARREADY_S_i  = s_arrdy;
        bus.RVALID_S_i   = s_rv;
        bus.RID_S_i      = s_rid;
        bus.RDATA_S_i    = s_rdata;
        bus.RRESP_S_i    = s_rresp;
        bus.RLAST_S_i    = s_rlast;
    endtask

    task automatic sample();
        o_arrdy[0] = bus.ARREADY_M0_o; o_arrdy[1] = bus.ARREADY_M1_o;
        o_rv[0]    = bus.RVALID_M0_o;  o_rv[1]    = bus.RVALID_M1_o;
        o_rid[0]   = bus.RID_M0_o;     o_rid[1]   = bus.RID_M1_o;
        o_rdata[0] = bus.RDATA_M0_o;   o_rdata[1] = bus.RDATA_M1_o;
        o_rresp[0] = bus.RRESP_M0_o;   o_rresp[1] = bus.RRESP_M1_o;
        o_rlast[0] = bus.RLAST_M0_o;   o_rlast[1] = bus.RLAST_M1_o;
    endtask

    task automatic settle();
        drive();
        #1;
        sample();
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        for (int i = 0; i < 2; i++) begin
            m_arv[i] = 1'b0; m_id[i] = '0; m_addr[i] = '0; m_len[i] = '0;
            m_size[i] = '0; m_burst[i] = '0; m_rrdy[i] = 1'b0;
        end
        s_arrdy = 1'b0; s_rv = 1'b0; s_rlast = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0;
    endtask

    task automatic check_all_zero(input string tag);
        sample();
        check_val({tag, "_arvalid_s"}, bus.ARVALID_S_o, 0);
        check_val({tag, "_ar_s"}, {bus.ARID_S_o, bus.ARADDR_S_o, bus.ARLEN_S_o, bus.ARSIZE_S_o, bus.ARBURST_S_o}, 0);
        check_val({tag, "_rready_s"}, bus.RREADY_S_o, 0);
        check_val({tag, "_arready"}, {o_arrdy[1], o_arrdy[0]}, 0);
        check_val({tag, "_rvalid"}, {o_rv[1], o_rv[0], o_rlast[1], o_rlast[0]}, 0);
        check_val({tag, "_rdata"}, {o_rdata[1], o_rdata[0]}, 0);
        check_val({tag, "_state"}, dbg_state, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        clear_inputs();
        settle();
        tick();
        tick();
        rst_n = 1'b1;
        model_last = 1;
        exp_q.delete();
    endtask

    task automatic rand_fields(input int g);
        m_id[g]    = ID_W'($urandom);
        m_len[g]   = LEN_W'($urandom_range(0, 15));
        m_size[g]  = SIZE_W'($urandom);
        m_burst[g] = 2'($urandom);
        if (DECERR_ON && $urandom_range(0, 3) != 0)
            m_addr[g] = BASE + $urandom_range(0, RANGE - 1);
        else
            m_addr[g] = $urandom;
    endtask

    // Serves one granted burst; called at the negedge after the grant edge.
    task automatic serve_burst(input int g, output bit aborted);
        int o, stall, idx, budget, n;
        bit tog;
        logic [IDS_W-1:0] exp_arid;
        logic [DATA_W-1:0] bd[16];
        logic [1:0] br[16];
        logic [DATA_W+2:0] e;
        o = 1 - g;
        n = int'(m_len[g]) + 1;
        exp_arid = {tag_of(g), m_id[g]};
        aborted = 1'b0;
        idx = 0; budget = 0; tog = 1'b1;
        if (model_fwd(m_addr[g])) begin
            stall = (stall_cfg < 0) ? int'($urandom_range(0, 3)) : stall_cfg;
            for (int c = 0; c <= stall; c++) begin
                s_arrdy = (c == stall);
                settle();
                check_val("arvalid_s", bus.ARVALID_S_o, 1);
                check_val("arid_s", bus.ARID_S_o, exp_arid);
                check_val("araddr_s", bus.ARADDR_S_o, m_addr[g]);
                check_val("arlen_size_burst_s", {bus.ARLEN_S_o, bus.ARSIZE_S_o, bus.ARBURST_S_o},
                          {m_len[g], m_size[g], m_burst[g]});
                check_val("arready_busy", {o_arrdy[1], o_arrdy[0]}, 0);
                tick();
            end
            s_arrdy = 1'b0;
            for (int b = 0; b < n; b++) begin
                bd[b] = $urandom;
                br[b] = 2'($urandom);
                exp_q.push_back({(b == n - 1), br[b], bd[b]});
            end
            while (idx < n && budget < 300) begin
                if (abort_after >= 0 && idx == abort_after) begin
                    s_rv = 1'b1; s_rdata = bd[idx]; s_rresp = br[idx]; s_rlast = (idx == n - 1);
                    settle();
                    #2 rst_n = 1'b0;
                    #1 check_all_zero("async_rst");
                    exp_q.delete();
                    model_last = 1;
                    aborted = 1'b1;
                    clear_inputs();
                    tick();
                    tick();
                    rst_n = 1'b1;
                    return;
                end
                s_rv    = (rrdy_mode == 1) ? 1'b1 : ($urandom_range(0, 3) != 0);
                s_rdata = bd[idx];
                s_rresp = br[idx];
                s_rlast = (idx == n - 1);
                s_rid   = {4'($urandom), m_id[g]};
                m_rrdy[g] = (rrdy_mode == 1) ? tog : 1'($urandom_range(0, 1));
                m_rrdy[o] = 1'($urandom_range(0, 1));
                tog = ~tog;
                settle();
                check_val("rready_s", bus.RREADY_S_o, m_rrdy[g]);
                check_val("rvalid_granted", o_rv[g], s_rv);
                check_val("rvalid_other", {o_rv[o], o_rlast[o], o_rdata[o]}, 0);
                check_val("arvalid_s_in_data", bus.ARVALID_S_o, 0);
                if (s_rv && m_rrdy[g]) begin
                    e = exp_q.pop_front();
                    check_val("rid", o_rid[g], m_id[g]);
                    check_val("rdata", o_rdata[g], e[DATA_W-1:0]);
                    check_val("rresp", o_rresp[g], e[DATA_W+1:DATA_W]);
                    check_val("rlast", o_rlast[g], e[DATA_W+2]);
                    idx++;
                end
                budget++;
                tick();
            end
            s_rv = 1'b0; s_rlast = 1'b0;
        end else begin
            while (idx < n && budget < 300) begin
                m_rrdy[g] = (rrdy_mode == 1) ? tog : 1'($urandom_range(0, 1));
                m_rrdy[o] = 1'($urandom_range(0, 1));
                s_rv = 1'($urandom_range(0, 1));
                tog = ~tog;
                settle();
                check_val("err_arvalid_s", bus.ARVALID_S_o, 0);
                check_val("err_rready_s", bus.RREADY_S_o, 0);
                check_val("err_rvalid", {o_rv[g], o_rv[o]}, 2'b10);
                check_val("err_beat", {o_rid[g], o_rresp[g], o_rdata[g]}, {m_id[g], 2'b11, 32'h0});
                check_val("err_rlast", o_rlast[g], (idx == n - 1));
                if (m_rrdy[g]) idx++;
                budget++;
                tick();
            end
            s_rv = 1'b0;
        end
        check_val("beats_done", idx, n);
    endtask

    // Runs until every requesting master in m_arv has been served in model order.
    task automatic run_round();
        bit pend[2];
        int g;
        bit ab;
        pend[0] = m_arv[0];
        pend[1] = m_arv[1];
        while (pend[0] || pend[1]) begin
            g = model_pick(pend[0], pend[1]);
            settle();
            check_val("arready_grant", o_arrdy[g], 1);
            check_val("arready_nogrant", o_arrdy[1 - g], 0);
            tick();
            model_last = g;
            pend[g] = 1'b0;
            m_arv[g] = 1'b0;
            serve_burst(g, ab);
            if (ab) return;
            if (rereq > 0) begin
                rereq--;
                rand_fields(g);
                m_arv[g] = 1'b1;
                pend[g] = 1'b1;
            end
        end
        settle();
        check_val("idle_after_round", dbg_state, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        clear_inputs();
        m_arv[0] = 1'b1;
        m_arv[1] = 1'b1;
        settle();
        check_all_zero("reset");
        do_reset();

        // single M0 read
        m_id[0] = 4'h5; m_addr[0] = 32'h100; m_len[0] = 4'd3; m_size[0] = 3'd2; m_burst[0] = 2'b01;
        m_arv[0] = 1'b1;
        stall_cfg = 0;
        run_round();
        stall_cfg = -1;

        // contention from reset, with M0 re-requesting so the grant alternates
        do_reset();
        rand_fields(0); rand_fields(1);
        m_arv[0] = 1'b1; m_arv[1] = 1'b1;
        rereq = 1;
        run_round();
        rereq = 0;

        // backpressure on AR and R
        rand_fields(1);
        m_addr[1] = BASE + 32'h80; m_len[1] = 4'd3;
        m_arv[1] = 1'b1;
        stall_cfg = 5; rrdy_mode = 1;
        run_round();
        stall_cfg = -1; rrdy_mode = 0;

        // async reset after beat 2 of 4, then a fresh M1 request
        rand_fields(0);
        m_addr[0] = BASE + 32'h40; m_len[0] = 4'd3;
        m_arv[0] = 1'b1;
        abort_after = 2; rrdy_mode = 1;
        run_round();
        abort_after = -1; rrdy_mode = 0;
        rand_fields(1);
        m_addr[1] = BASE + 32'h20;
        m_arv[1] = 1'b1;
        run_round();

        // M1 read outside the window
        rand_fields(1);
        m_addr[1] = 32'h2000_0000; m_len[1] = 4'd1;
        m_arv[1] = 1'b1;
        run_round();

        for (int r = 0; r < 40; r++) begin
            rand_fields(0); rand_fields(1);
            case ($urandom_range(0, 2))
                0:       m_arv[0] = 1'b1;
                1:       m_arv[1] = 1'b1;
                default: begin m_arv[0] = 1'b1; m_arv[1] = 1'b1; end
            endcase
            rereq = int'($urandom_range(0, 1));
            run_round();
            rereq = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
